// File: rtl/pcie_tlp_initiator.sv
// pcie_tlp_initiator
// Requester-side TLP engine for a 16-bit PCIe TLP interface. Turns single-DW
// local master requests into MWr32/MRd32 TLPs and matches the returning
// Cpl/CplD to hand read data (or an error) back to the local master.
// Optional feature macro: PCIE_CPL_TIMEOUT_EN enables a completion timeout of
// TIMEOUT_CYCLES pcie_clk cycles; without it a read waits for its completion
// indefinitely.

module pcie_tlp_initiator #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000
) (
  input  logic        pcie_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  bus_num,
  input  logic [4:0]  dev_num,
  input  logic [2:0]  func_num,
  output logic        tx_req,
  input  logic        tx_rdy,
  output logic        tx_st,
  output logic        tx_end,
  output logic [15:0] tx_data,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [15:0] rx_data,
  input  logic        mst_req,
  input  logic        mst_we,
  input  logic [29:0] mst_adr,
  input  logic [3:0]  mst_be,
  input  logic [31:0] mst_wdat,
  output logic        mst_ack,
  output logic        mst_busy,
  output logic        mst_rvalid,
  output logic [31:0] mst_rdat,
  output logic        mst_err
);

  // Request FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // Fixed header halfwords and completion type codes
  localparam logic [15:0] H0_MWR  = 16'h4000;
  localparam logic [15:0] H0_MRD  = 16'h0000;
  localparam logic [15:0] H1_LEN1 = 16'h0001;
  localparam logic [15:0] TYPE_CPLD = 16'h4A00;
  localparam logic [15:0] TYPE_CPL  = 16'h0A00;

  // Last beat index: MWr carries two data halfwords after the 6-beat header
  localparam logic [2:0] LAST_MWR = 3'd7;
  localparam logic [2:0] LAST_MRD = 3'd5;

  // The expiry compare looks two counts ahead so that the registered error
  // pulse is visible exactly TIMEOUT_CYCLES cycles after tx_end.
  if (TIMEOUT_CYCLES < 32'd2) begin : g_timeout_too_small
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // Halfword of the outgoing TLP for a given beat index.
  function automatic logic [15:0] tlp_halfword(
    input logic [2:0]  idx,
    input logic        is_wr,
    input logic [15:0] req_id,
    input logic [4:0]  tag,
    input logic [3:0]  be,
    input logic [29:0] dw_adr,
    input logic [31:0] wdat
  );
    logic [15:0] hw;
    hw = 16'h0000;
    case (idx)
      3'd0: begin
        if (is_wr) hw = H0_MWR;
        else       hw = H0_MRD;
      end
      3'd1:    hw = H1_LEN1;
      3'd2:    hw = req_id;
      3'd3:    hw = {3'b000, tag, 4'b0000, be};
      3'd4:    hw = dw_adr[29:14];
      3'd5:    hw = {dw_adr[13:0], 2'b00};
      3'd6:    hw = wdat[31:16];
      3'd7:    hw = wdat[15:0];
      default: hw = 16'h0000;
    endcase
    return hw;
  endfunction

  // Request side state
  logic [1:0]  state_r;
  logic [2:0]  beat_r;
  logic [4:0]  tag_r;
  logic        we_r;
  logic [29:0] adr_r;
  logic [3:0]  be_r;
  logic [31:0] wdat_r;

  // Registered outputs
  logic        tx_req_r;
  logic        tx_st_r;
  logic        tx_end_r;
  logic [15:0] tx_data_r;
  logic        mst_ack_r;
  logic        mst_busy_r;
  logic        mst_rvalid_r;
  logic [31:0] mst_rdat_r;
  logic        mst_err_r;

  // Rx parser state and captured completion fields
  logic [2:0]  rx_beat_r;
  logic        rx_in_tlp_r;
  logic [15:0] rx_type_r;
  logic [2:0]  rx_status_r;
  logic [15:0] rx_reqid_r;
  logic [7:0]  rx_tag_r;
  logic [15:0] rx_d0_r;
  logic [15:0] rx_d1_r;

  // Combinational helpers
  logic [15:0] own_id_s;
  logic [2:0]  last_beat_s;
  logic [2:0]  beat_next_s;
  logic        send_done_s;
  logic [2:0]  rx_idx_s;
  logic        rx_active_s;
  logic [15:0] eff_type_s;
  logic [2:0]  eff_status_s;
  logic [15:0] eff_reqid_s;
  logic [7:0]  eff_tag_s;
  logic [15:0] eff_d0_s;
  logic [15:0] eff_d1_s;
  logic        cpl_hit_s;
  logic        cpl_good_s;
  logic        tmo_expire_s;

  assign own_id_s = {bus_num, dev_num, func_num};

  // Beat bookkeeping for the tx serializer
  always_comb begin
    last_beat_s = LAST_MRD;
    if (we_r) last_beat_s = LAST_MWR;
    else      last_beat_s = LAST_MRD;
    beat_next_s = beat_r + 3'd1;
    send_done_s = (state_r == ST_SEND) && (beat_r == last_beat_s);
  end

  // Field values as seen this cycle: the beat on rx_data overrides the
  // captured copy, so the match can be decided on the rx_end beat itself.
  always_comb begin
    rx_idx_s     = rx_beat_r;
    rx_active_s  = rx_st | rx_in_tlp_r;
    eff_type_s   = rx_type_r;
    eff_status_s = rx_status_r;
    eff_reqid_s  = rx_reqid_r;
    eff_tag_s    = rx_tag_r;
    eff_d0_s     = rx_d0_r;
    eff_d1_s     = rx_d1_r;
    if (rx_st) rx_idx_s = 3'd0;
    else       rx_idx_s = rx_beat_r;
    if (rx_active_s) begin
      case (rx_idx_s)
        3'd0:    eff_type_s   = rx_data;
        3'd3:    eff_status_s = rx_data[15:13];
        3'd4:    eff_reqid_s  = rx_data;
        3'd5:    eff_tag_s    = rx_data[15:8];
        3'd6:    eff_d0_s     = rx_data;
        3'd7:    eff_d1_s     = rx_data;
        default: eff_type_s   = rx_type_r;
      endcase
    end else begin
      eff_type_s = rx_type_r;
    end
  end

  // Completion match: right type, addressed to us, carrying the live tag
  always_comb begin
    cpl_hit_s  = 1'b0;
    cpl_good_s = 1'b0;
    if ((state_r == ST_WAIT) && rx_end && rx_active_s &&
        ((eff_type_s == TYPE_CPLD) || (eff_type_s == TYPE_CPL)) &&
        (eff_reqid_s == own_id_s) && (eff_tag_s == {3'b000, tag_r})) begin
      cpl_hit_s = 1'b1;
    end else begin
      cpl_hit_s = 1'b0;
    end
    if ((eff_type_s == TYPE_CPLD) && (eff_status_s == 3'b000)) cpl_good_s = 1'b1;
    else                                                       cpl_good_s = 1'b0;
  end

`ifdef PCIE_CPL_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;

  // Completion timeout counter: cleared at MRd tx_end, runs while waiting
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt_r <= 32'd0;
    end else if (send_done_s && !we_r) begin
      tmo_cnt_r <= 32'd0;
    end else if (state_r == ST_WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign tmo_expire_s = (state_r == ST_WAIT) && (tmo_cnt_r == (TIMEOUT_CYCLES - 32'd2));
`else
  assign tmo_expire_s = 1'b0;
`endif

  // Rx parser: beat tracking and field capture, independent of the FSM
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_beat_r   <= 3'd0;
      rx_in_tlp_r <= 1'b0;
      rx_type_r   <= 16'h0000;
      rx_status_r <= 3'b000;
      rx_reqid_r  <= 16'h0000;
      rx_tag_r    <= 8'h00;
      rx_d0_r     <= 16'h0000;
      rx_d1_r     <= 16'h0000;
    end else begin
      if (rx_end) begin
        rx_beat_r   <= 3'd0;
        rx_in_tlp_r <= 1'b0;
      end else if (rx_active_s) begin
        if (rx_idx_s == 3'd7) begin
          // Longer than any completion we care about: drop the rest
          rx_beat_r   <= 3'd0;
          rx_in_tlp_r <= 1'b0;
        end else begin
          rx_beat_r   <= rx_idx_s + 3'd1;
          rx_in_tlp_r <= 1'b1;
        end
      end else begin
        rx_beat_r   <= rx_beat_r;
        rx_in_tlp_r <= rx_in_tlp_r;
      end
      rx_type_r   <= eff_type_s;
      rx_status_r <= eff_status_s;
      rx_reqid_r  <= eff_reqid_s;
      rx_tag_r    <= eff_tag_s;
      rx_d0_r     <= eff_d0_s;
      rx_d1_r     <= eff_d1_s;
    end
  end

  // Request FSM, tx serializer and master-side handshake
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= ST_IDLE;
      beat_r       <= 3'd0;
      tag_r        <= 5'd0;
      we_r         <= 1'b0;
      adr_r        <= 30'd0;
      be_r         <= 4'h0;
      wdat_r       <= 32'h0000_0000;
      tx_req_r     <= 1'b0;
      tx_st_r      <= 1'b0;
      tx_end_r     <= 1'b0;
      tx_data_r    <= 16'h0000;
      mst_ack_r    <= 1'b0;
      mst_busy_r   <= 1'b0;
      mst_rvalid_r <= 1'b0;
      mst_rdat_r   <= 32'h0000_0000;
      mst_err_r    <= 1'b0;
    end else begin
      mst_ack_r    <= 1'b0;
      mst_rvalid_r <= 1'b0;
      mst_err_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mst_req) begin
            we_r       <= mst_we;
            adr_r      <= mst_adr;
            be_r       <= mst_be;
            wdat_r     <= mst_wdat;
            mst_ack_r  <= 1'b1;
            mst_busy_r <= 1'b1;
            tx_req_r   <= 1'b1;
            state_r    <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (tx_rdy) begin
            tx_req_r  <= 1'b0;
            beat_r    <= 3'd0;
            tx_st_r   <= 1'b1;
            tx_end_r  <= 1'b0;
            tx_data_r <= tlp_halfword(3'd0, we_r, own_id_s, tag_r, be_r, adr_r, wdat_r);
            state_r   <= ST_SEND;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_SEND: begin
          if (send_done_s) begin
            tx_st_r   <= 1'b0;
            tx_end_r  <= 1'b0;
            tx_data_r <= 16'h0000;
            beat_r    <= 3'd0;
            if (we_r) begin
              // Posted write: nothing comes back
              mst_busy_r <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            beat_r    <= beat_next_s;
            tx_st_r   <= 1'b0;
            tx_end_r  <= (beat_next_s == last_beat_s);
            tx_data_r <= tlp_halfword(beat_next_s, we_r, own_id_s, tag_r, be_r, adr_r, wdat_r);
          end
        end
        ST_WAIT: begin
          // A matching completion on the expiry cycle takes priority
          if (cpl_hit_s) begin
            tag_r      <= tag_r + 5'd1;
            mst_busy_r <= 1'b0;
            state_r    <= ST_IDLE;
            if (cpl_good_s) begin
              mst_rvalid_r <= 1'b1;
              mst_rdat_r   <= {eff_d0_s, eff_d1_s};
            end else begin
              mst_err_r  <= 1'b1;
              mst_rdat_r <= 32'h0000_0000;
            end
          end else if (tmo_expire_s) begin
            tag_r      <= tag_r + 5'd1;
            mst_err_r  <= 1'b1;
            mst_busy_r <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_req     = tx_req_r;
  assign tx_st      = tx_st_r;
  assign tx_end     = tx_end_r;
  assign tx_data    = tx_data_r;
  assign mst_ack    = mst_ack_r;
  assign mst_busy   = mst_busy_r;
  assign mst_rvalid = mst_rvalid_r;
  assign mst_rdat   = mst_rdat_r;
  assign mst_err    = mst_err_r;

endmodule
